// File: rtl/hazard_stall_unit.sv
// Hazard stall/bubble generator for the 5-stage pipeline.
// Covers the hazards that operand forwarding cannot resolve:
//   - load-use on a GPR or on LR: a one-cycle decode hold plus a DeEx bubble.
//   - a variable-latency memory access in ExMe: the front of the pipe is
//     frozen and MeWb receives bubbles until the memory responds.
// Also keeps a saturating count of PC-stall cycles and a sticky watchdog
// flag that sets when a memory wait runs too long.
module hazard_stall_unit #(
  parameter int SEL_W    = 5,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             FeDe_valid,
  input  logic [SEL_W-1:0] FeDe_reg_1_sel,
  input  logic [SEL_W-1:0] FeDe_reg_2_sel,
  input  logic             FeDe_reg_1_rd,
  input  logic             FeDe_reg_2_rd,
  input  logic             FeDe_LR_read,
  input  logic             DeEx_valid,
  input  logic             DeEx_mem_read,
  input  logic             DeEx_reg_write_en,
  input  logic [SEL_W-1:0] DeEx_reg_wrt_sel,
  input  logic             DeEx_LR_write,
  input  logic             ExMe_valid,
  input  logic             ExMe_mem_access,
  input  logic             mem_resp_valid,
  output logic             stall_pc,
  output logic             stall_FeDe,
  output logic             stall_DeEx,
  output logic             stall_ExMe,
  output logic             bubble_DeEx,
  output logic             bubble_MeWb,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout,
  output logic             hazard_state
);

  // 12 bits covers the full legal MAX_WAIT range.
  localparam int WAIT_W = 12;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic gpr_hit, lr_hit, load_use, mem_block;
  logic freeze, lu_stall;

  // Hazard detection: r0 is hardwired zero, so a load to r0 never hazards.
  always_comb begin
    gpr_hit   = DeEx_reg_write_en && (DeEx_reg_wrt_sel != '0) &&
                ((FeDe_reg_1_rd && (FeDe_reg_1_sel == DeEx_reg_wrt_sel)) ||
                 (FeDe_reg_2_rd && (FeDe_reg_2_sel == DeEx_reg_wrt_sel)));
    lr_hit    = DeEx_LR_write && FeDe_LR_read;
    load_use  = FeDe_valid && DeEx_valid && DeEx_mem_read && (gpr_hit || lr_hit);
    mem_block = ExMe_valid && ExMe_mem_access && !mem_resp_valid;
  end

  // Next state and stall outputs; a memory freeze masks load-use because the
  // held DeEx instruction is not advancing anyway.
  always_comb begin
    state_d  = state_q;
    freeze   = 1'b0;
    lu_stall = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (mem_block) begin
            freeze  = 1'b1;
            state_d = MEM_WAIT;
          end else if (load_use) begin
            lu_stall = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!mem_resp_valid) begin
            freeze = 1'b1;
          end else begin
            // The response releases the pipe this very cycle.
            state_d  = RUN;
            lu_stall = load_use;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign stall_pc     = freeze | lu_stall;
  assign stall_FeDe   = freeze | lu_stall;
  assign stall_DeEx   = freeze;
  assign stall_ExMe   = freeze;
  assign bubble_DeEx  = lu_stall;
  assign bubble_MeWb  = freeze;
  assign stall_count  = stall_cnt_q;
  assign mem_timeout  = timeout_q;
  assign hazard_state = state_q;

  // Watchdog and stall counter next values; the wait count saturates at the
  // limit so the timeout flag cannot be missed by wrap-around.
  always_comb begin
    wait_d      = '0;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    if ((state_q == MEM_WAIT) && !mem_resp_valid) begin
      wait_d = (wait_q >= WAIT_LIMIT) ? wait_q : wait_q + 1'b1;
      if (wait_d == WAIT_LIMIT) begin
        timeout_d = 1'b1;
      end
    end
    if (stall_pc && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State, watchdog and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
